// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 keyboard front end: scan-code prefixes,
// decoder state encoding and the default key-code table entries.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PAUSE = 8'hE1;

    // start + 8 data + parity + stop
    localparam logic [3:0] PS2_FRAME_BITS = 4'd11;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    // bit 8 marks an E0-extended code
    localparam logic [8:0] KEY_UP     = 9'h175;
    localparam logic [8:0] KEY_DOWN   = 9'h172;
    localparam logic [8:0] KEY_LEFT   = 9'h16b;
    localparam logic [8:0] KEY_RIGHT  = 9'h174;
    localparam logic [8:0] KEY_OK     = 9'h029;
    localparam logic [8:0] KEY_SWITCH = 9'h014;

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 byte receiver: synchronises and glitch-filters the raw lines, deframes
// 11-bit frames, checks start/parity/stop and abandons stalled frames.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int unsigned FILT_LEN    = 8,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int unsigned FW = $clog2(FILT_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          clk_s, data_s;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          fall;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          start_q, start_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [7:0]    byte_q, byte_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic          frame_ok;

    assign clk_s  = clk_sync_q[1];
    assign data_s = data_sync_q[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
        end
    end

    // Filtered level flips on the FILT_LEN-th consecutive differing sample.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        fall   = 1'b0;
        if (clk_s == filt_q) begin
            fcnt_d = '0;
        end else if (fcnt_q == FW'(FILT_LEN - 1)) begin
            filt_d = clk_s;
            fcnt_d = '0;
            fall   = filt_q;
        end else begin
            fcnt_d = fcnt_q + 1'b1;
        end
    end

    assign frame_ok = !start_q && (^{shift_q, par_q}) && data_s;

    always_comb begin
        bitcnt_d = bitcnt_q;
        shift_d  = shift_q;
        start_d  = start_q;
        par_d    = par_q;
        tmo_d    = tmo_q;
        byte_d   = byte_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        if (fall) begin
            tmo_d = '0;
            if (bitcnt_q == 4'd0) begin
                start_d = data_s;
            end else if (bitcnt_q <= 4'd8) begin
                shift_d = {data_s, shift_q[7:1]};
            end else if (bitcnt_q == 4'd9) begin
                par_d = data_s;
            end
            if (bitcnt_q == PS2_FRAME_BITS - 4'd1) begin
                bitcnt_d = '0;
                byte_d   = shift_q;
                valid_d  = frame_ok;
                err_d    = !frame_ok;
            end else begin
                bitcnt_d = bitcnt_q + 4'd1;
            end
        end else if (bitcnt_q == 4'd0) begin
            tmo_d = '0;
        end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            bitcnt_d = '0;
            tmo_d    = '0;
        end else begin
            tmo_d = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_q   <= 1'b1;
            fcnt_q   <= '0;
            bitcnt_q <= '0;
            shift_q  <= '0;
            start_q  <= 1'b0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            byte_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            filt_q   <= filt_d;
            fcnt_q   <= fcnt_d;
            bitcnt_q <= bitcnt_d;
            shift_q  <= shift_d;
            start_q  <= start_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
            byte_q   <= byte_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign byte_out   = byte_q;
    assign byte_valid = valid_q;
    assign frame_err  = err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: resolves E0/F0 prefixes into make/break events for
// a table of keys and produces held levels, press/release pulses and auto-repeat.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned           N_KEYS        = 6,
    // entry i sits at KEY_CODES[i*9 +: 9], so entry 0 is the rightmost item
    parameter logic [N_KEYS*9-1:0]   KEY_CODES     = {KEY_UP, KEY_DOWN, KEY_LEFT,
                                                      KEY_RIGHT, KEY_OK, KEY_SWITCH},
    parameter int unsigned           FILT_LEN      = 8,
    parameter int unsigned           TIMEOUT_CYC   = 50000,
    parameter int unsigned           REPEAT_DELAY  = 25000000,
    parameter int unsigned           REPEAT_PERIOD = 5000000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             ps2_clk,
    input  logic                             ps2_data,
    output logic [N_KEYS-1:0]                key_held,
    output logic [N_KEYS-1:0]                key_press,
    output logic [N_KEYS-1:0]                key_release,
    output logic [$clog2(N_KEYS+1)-1:0]      whichkey,
    output logic                             frame_err
);

    localparam int unsigned WK_W = $clog2(N_KEYS + 1);
    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    logic [7:0]        rx_byte;
    logic              rx_valid;
    logic              rx_err;
    logic [1:0]        state_q, state_d;
    logic              ev_make, ev_break;
    logic [8:0]        code;
    logic [N_KEYS-1:0] match, new_press, rel, sel_new;
    logic [N_KEYS-1:0] held_q, held_d;
    logic [N_KEYS-1:0] press_q, press_d;
    logic [N_KEYS-1:0] rel_q;
    logic [WK_W-1:0]   wk_q, wk_d;
    logic [N_KEYS-1:0] sel_q, sel_d;
    logic              act_q, act_d;
    logic [RW-1:0]     rcnt_q, rcnt_d;
    logic              tick;

    ps2_rx_frame #(
        .FILT_LEN    (FILT_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_out   (rx_byte),
        .byte_valid (rx_valid),
        .frame_err  (rx_err)
    );

    always_comb begin
        state_d  = state_q;
        ev_make  = 1'b0;
        ev_break = 1'b0;
        code     = {1'b0, rx_byte};
        if (rx_err) begin
            state_d = ST_IDLE;
        end else if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == PS2_EXT)        state_d = ST_EXT;
                    else if (rx_byte == PS2_BRK)   state_d = ST_BRK;
                    else if (rx_byte != PS2_PAUSE) ev_make = 1'b1;
                end
                ST_EXT: begin
                    if (rx_byte == PS2_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (rx_byte != PS2_EXT) begin
                        ev_make = 1'b1;
                        code    = {1'b1, rx_byte};
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    ev_break = 1'b1;
                    state_d  = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    ev_break = 1'b1;
                    code     = {1'b1, rx_byte};
                    state_d  = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_KEYS; i++) begin
            match[i] = (KEY_CODES[i*9 +: 9] == code);
        end
        new_press = ev_make  ? (match & ~held_q) : '0;
        rel       = ev_break ? (match & held_q)  : '0;
        held_d    = (held_q | new_press) & ~rel;
        sel_new   = new_press & (~new_press + 1'b1);
    end

    // A release of the repeating key outranks its tick; a new press outranks both.
    assign tick = act_q && (rcnt_q == RW'(1));

    always_comb begin
        press_d = new_press;
        sel_d   = sel_q;
        act_d   = act_q;
        rcnt_d  = rcnt_q;
        if (|new_press) begin
            sel_d  = sel_new;
            act_d  = (REPEAT_DELAY != 0);
            rcnt_d = RW'(REPEAT_DELAY);
        end else if (act_q && |(rel & sel_q)) begin
            act_d = 1'b0;
        end else if (tick) begin
            press_d = sel_q;
            rcnt_d  = RW'(REPEAT_PERIOD);
        end else if (act_q) begin
            rcnt_d = rcnt_q - 1'b1;
        end
    end

    always_comb begin
        wk_d = '0;
        for (int unsigned i = N_KEYS; i > 0; i--) begin
            if (held_q[i-1]) wk_d = WK_W'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            held_q  <= '0;
            press_q <= '0;
            rel_q   <= '0;
            wk_q    <= '0;
            sel_q   <= '0;
            act_q   <= 1'b0;
            rcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            held_q  <= held_d;
            press_q <= press_d;
            rel_q   <= rel;
            wk_q    <= wk_d;
            sel_q   <= sel_d;
            act_q   <= act_d;
            rcnt_q  <= rcnt_d;
        end
    end

    assign key_held    = held_q;
    assign key_press   = press_q;
    assign key_release = rel_q;
    assign whichkey    = wk_q;
    assign frame_err   = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a table of scan-code sequences plus
// hand-written auto-repeat, parity, timeout and reset sequences.
module tb_ps2_key_decoder;

    localparam int unsigned TMO = 100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic [5:0] held, press, rls;
    logic [2:0] wk;
    logic       ferr;
    logic [5:0] r_held, r_press, r_rls;
    logic [2:0] r_wk;
    logic       r_ferr;

    always #5 clk = ~clk;

    ps2_key_decoder #(
        .N_KEYS        (6),
        .FILT_LEN      (2),
        .TIMEOUT_CYC   (TMO),
        .REPEAT_DELAY  (0),
        .REPEAT_PERIOD (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_held    (held),
        .key_press   (press),
        .key_release (rls),
        .whichkey    (wk),
        .frame_err   (ferr)
    );

    ps2_key_decoder #(
        .N_KEYS        (6),
        .FILT_LEN      (2),
        .TIMEOUT_CYC   (TMO),
        .REPEAT_DELAY  (20),
        .REPEAT_PERIOD (5)
    ) dut_r (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .key_held    (r_held),
        .key_press   (r_press),
        .key_release (r_rls),
        .whichkey    (r_wk),
        .frame_err   (r_ferr)
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int press_cnt [6] = '{default: 0};
    int rls_cnt [6]   = '{default: 0};
    int err_cnt = 0;
    int p0 [6];
    int r0 [6];
    int e0;

    bit   rec_en = 1'b0;
    int   rp_q [$];
    int   r_rel_t = 0;
    logic h0_prev = 1'b0;
    logic rise_pend = 1'b0;
    logic [2:0] wk_rise = 3'h7;
    logic [2:0] wk_after = 3'h7;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = 0; i < 6; i++) begin
            if (press[i]) press_cnt[i] <= press_cnt[i] + 1;
            if (rls[i])   rls_cnt[i]   <= rls_cnt[i] + 1;
        end
        if (ferr) err_cnt <= err_cnt + 1;
        if (rec_en) begin
            if (r_press[0]) rp_q.push_back(cyc);
            if (r_rls[0])   r_rel_t <= cyc;
        end
        if (rise_pend) wk_after <= wk;
        rise_pend <= held[0] && !h0_prev;
        if (held[0] && !h0_prev) wk_rise <= wk;
        h0_prev <= held[0];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [10:0] fr, input int unsigned nbits);
        for (int unsigned k = 0; k < nbits; k++) begin
            ps2_data = fr[k];
            repeat (4) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (6) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (2) @(negedge clk);
        end
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit bad_par);
        send_bits(mk_frame(b, bad_par), 11);
        ps2_data = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic snap();
        for (int i = 0; i < 6; i++) begin
            p0[i] = press_cnt[i];
            r0[i] = rls_cnt[i];
        end
        e0 = err_cnt;
    endtask

    task automatic check_deltas(input string tag, input logic [5:0] exp_p,
                                input logic [5:0] exp_r, input int exp_e);
        logic [5:0] pm, rm;
        int pt, rt;
        pt = 0;
        rt = 0;
        for (int i = 0; i < 6; i++) begin
            pm[i] = (press_cnt[i] != p0[i]);
            rm[i] = (rls_cnt[i] != r0[i]);
            pt += press_cnt[i] - p0[i];
            rt += rls_cnt[i] - r0[i];
        end
        check({tag, " press mask"}, pm, exp_p);
        check({tag, " press count"}, pt, $countones(exp_p));
        check({tag, " release mask"}, rm, exp_r);
        check({tag, " release count"}, rt, $countones(exp_r));
        check({tag, " frame_err count"}, err_cnt - e0, exp_e);
    endtask

    typedef struct {
        int unsigned n;
        logic [23:0] bytes;
        logic [5:0]  held;
        logic [2:0]  wk;
        logic [5:0]  press;
        logic [5:0]  rls;
    } vec_t;

    vec_t vt [18];
    int   exp_off [6] = '{0, 20, 25, 30, 35, 40};

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected < 60000", cyc);
        $fatal(1);
    end

    initial begin
        int p_t, r_t, exp_cnt, off;

        vt[0]  = '{1, 24'h000075, 6'b000000, 3'd0, 6'b000000, 6'b000000};
        vt[1]  = '{2, 24'h0075F0, 6'b000000, 3'd0, 6'b000000, 6'b000000};
        vt[2]  = '{2, 24'h0075E0, 6'b100000, 3'd6, 6'b100000, 6'b000000};
        vt[3]  = '{3, 24'h75F0E0, 6'b000000, 3'd0, 6'b000000, 6'b100000};
        vt[4]  = '{1, 24'h000029, 6'b000010, 3'd2, 6'b000010, 6'b000000};
        vt[5]  = '{1, 24'h000029, 6'b000010, 3'd2, 6'b000000, 6'b000000};
        vt[6]  = '{1, 24'h000029, 6'b000010, 3'd2, 6'b000000, 6'b000000};
        vt[7]  = '{1, 24'h000029, 6'b000010, 3'd2, 6'b000000, 6'b000000};
        vt[8]  = '{2, 24'h0029F0, 6'b000000, 3'd0, 6'b000000, 6'b000010};
        vt[9]  = '{2, 24'h006BE0, 6'b001000, 3'd4, 6'b001000, 6'b000000};
        vt[10] = '{1, 24'h000014, 6'b001001, 3'd1, 6'b000001, 6'b000000};
        vt[11] = '{3, 24'h6BF0E0, 6'b000001, 3'd1, 6'b000000, 6'b001000};
        vt[12] = '{2, 24'h0014F0, 6'b000000, 3'd0, 6'b000000, 6'b000001};
        vt[13] = '{2, 24'h0014E1, 6'b000001, 3'd1, 6'b000001, 6'b000000};
        vt[14] = '{2, 24'h0014F0, 6'b000000, 3'd0, 6'b000000, 6'b000001};
        vt[15] = '{2, 24'h0029F0, 6'b000000, 3'd0, 6'b000000, 6'b000000};
        vt[16] = '{3, 24'h74E0E0, 6'b000100, 3'd3, 6'b000100, 6'b000000};
        vt[17] = '{3, 24'h74F0E0, 6'b000000, 3'd0, 6'b000000, 6'b000100};

        idle(4);
        check("reset held", held, 0);
        check("reset whichkey", wk, 0);
        check("reset press", press, 0);
        check("reset release", rls, 0);
        check("reset frame_err", ferr, 0);
        check("reset r held", r_held, 0);
        check("reset r whichkey", r_wk, 0);
        rst = 1'b0;
        idle(5);

        for (int i = 0; i < 18; i++) begin
            snap();
            for (int unsigned j = 0; j < vt[i].n; j++) begin
                send_byte(vt[i].bytes[j*8 +: 8], 1'b0);
            end
            idle(12);
            check($sformatf("v%0d held", i), held, vt[i].held);
            check($sformatf("v%0d whichkey", i), wk, vt[i].wk);
            check_deltas($sformatf("v%0d", i), vt[i].press, vt[i].rls, 0);
        end

        // auto-repeat on the second instance
        rec_en = 1'b1;
        send_byte(8'h14, 1'b0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h14, 1'b0);
        idle(60);
        rec_en = 1'b0;
        check("rpt first press seen", rp_q.size() > 0, 1);
        check("rpt release seen", r_rel_t != 0, 1);
        if (rp_q.size() > 0) begin
            p_t = rp_q[0];
            r_t = r_rel_t;
            for (int k = 1; k < 6; k++) begin
                off = (k < rp_q.size()) ? rp_q[k] - p_t : -1;
                check($sformatf("rpt offset %0d", k), off, exp_off[k]);
            end
            exp_cnt = 1;
            if (r_t - 1 >= p_t + 20) exp_cnt = 2 + (r_t - 1 - p_t - 20) / 5;
            check("rpt pulse count", rp_q.size(), exp_cnt);
            check("rpt none at/after release", rp_q[rp_q.size()-1] < r_t, 1);
        end
        check("rpt held after release", r_held, 0);

        // parity error forces the prefix FSM back to idle
        snap();
        send_byte(8'hE0, 1'b0);
        send_byte(8'h29, 1'b1);
        send_byte(8'h75, 1'b0);
        idle(12);
        check("par held", held, 0);
        check_deltas("par", 6'b000000, 6'b000000, 1);
        snap();
        send_byte(8'h29, 1'b0);
        idle(12);
        check("par ok held", held, 6'b000010);
        check_deltas("par ok", 6'b000010, 6'b000000, 0);
        send_byte(8'hF0, 1'b0);
        send_byte(8'h29, 1'b0);
        idle(12);

        // stalled frame is abandoned without an error
        snap();
        send_bits(mk_frame(8'h14, 1'b0), 5);
        ps2_data = 1'b1;
        idle(TMO + 20);
        send_byte(8'h14, 1'b0);
        idle(12);
        check("tmo held", held, 6'b000001);
        check_deltas("tmo", 6'b000001, 6'b000000, 0);
        check("whichkey at held rise", wk_rise, 0);
        check("whichkey one cycle later", wk_after, 1);

        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst hold held", held, 0);
        check("rst hold whichkey", wk, 0);
        check("rst hold r held", r_held, 0);
        check("rst hold r whichkey", r_wk, 0);
        idle(3);
        rst = 1'b0;
        idle(5);

        // reset mid-frame: next frame decodes from a fresh start bit
        snap();
        send_bits(mk_frame(8'h14, 1'b0), 4);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        ps2_data = 1'b1;
        idle(5);
        send_byte(8'h29, 1'b0);
        idle(12);
        check("rst frame held", held, 6'b000010);
        check_deltas("rst frame", 6'b000010, 6'b000000, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
